controlador_estados: RTL and testbench
======================================

Name: controlador_estados

Overview:
- Pet behaviour state machine; sits directly upstream of the attribute controller.
- Drives the 5-bit `estado` bus that the attribute controller consumes.
- Takes the user buttons and the current fome/felicidade/sono values, and decides the pet's activity.
- Handles start, sleep, eat, teach, automatic end of an activity, and death.

Parameters:
- MAX_ATRIB, 100, attribute saturation value; an activity ends when its attribute equals this.
- ACT_TIMEOUT, 67108864, clock cycles an activity may last before forced return to IDLE; legal range 1 to 2^32-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- btn_start  in  1  start/restart button, active-high level, already debounced, asynchronous to clk
- btn_dormir  in  1  sleep button, same conventions
- btn_comer  in  1  eat button, same conventions
- btn_aula  in  1  teach button, same conventions
- fome  in  8  current hunger attribute, clk domain
- felicidade  in  8  current happiness attribute, clk domain
- sono  in  8  current sleep attribute, clk domain
- estado  out  5  current state; one-hot except INTRO: INTRO=00000, IDLE=00001, DORMINDO=00010, COMENDO=00100, DANDO_AULA=01000, MORTO=10000
- morto  out  1  registered; high exactly when estado==MORTO

Behaviour:
- Reset:
  - rst_n low immediately forces estado=INTRO and morto=0.
  - All synchronizer flops, edge-detect flops and the activity counter clear to 0.
  - Release is sampled on the next clk edge.
  - Reset asserted mid-activity aborts the activity; no residual counter value remains.
- Button path, applied per button:
  - 2-flop synchronizer, then an edge register; rise = sync2 & ~prev.
  - A level sampled high at clk edge k gives a rise pulse during cycle k+1.
  - estado updates at edge k+2.
  - A held button produces exactly one rise.
  - A glitch shorter than one clk period may be missed; this is acceptable.
- Activity counter (32 bits):
  - Cleared on every transition into DORMINDO, COMENDO or DANDO_AULA.
  - Increments each cycle while in one of those states; holds 0 in all other states.
- zero_any = (fome==0) | (felicidade==0) | (sono==0).
- Transitions, evaluated each clk edge; first matching rule wins:
  - INTRO: rise(btn_start) -> IDLE. Everything else is ignored.
  - MORTO: rise(btn_start) -> INTRO. Everything else is ignored; zero_any is ignored.
  - IDLE, in this order:
    - zero_any -> MORTO
    - rise(btn_dormir) -> DORMINDO
    - rise(btn_comer) -> COMENDO
    - rise(btn_aula) -> DANDO_AULA
    - otherwise stay.
  - Simultaneous rises follow the priority dormir > comer > aula; btn_start is ignored.
  - DORMINDO, COMENDO, DANDO_AULA, in this order:
    - zero_any -> MORTO.
    - Rise of the same button that started the activity -> IDLE (toggle off).
    - Rise of a different activity button -> that activity, using the IDLE priority order; the counter is cleared.
    - Own attribute == MAX_ATRIB -> IDLE. Own attribute: sono for DORMINDO, fome for COMENDO, felicidade for DANDO_AULA.
    - counter == ACT_TIMEOUT-1 -> IDLE.
    - otherwise stay.
- Attribute compare:
  - Equality against MAX_ATRIB, 8-bit.
  - Values above MAX_ATRIB are treated as "not max" and cause no exit via this rule.
- After MORTO -> INTRO the attributes are not reset by this block. If an attribute is still 0, the path INTRO -> IDLE -> MORTO takes one cycle per hop. This is correct behaviour.
- morto is registered alongside estado, so both change on the same edge.
- No other output states exist. estado never takes an encoding outside the six listed.

Test Plan:
- Reset and start: hold rst_n=0 mid-run, attributes 50/50/50 -> estado=00000 immediately, morto=0. Release, pulse btn_start for 3 cycles -> estado=00001 at the 3rd edge after btn_start is first sampled high, and it stays there.
- Enter and toggle off: in IDLE, raise btn_comer, then btn_comer and btn_aula together on a later press -> COMENDO, then IDLE on the second comer rise; aula is ignored because toggle-off has priority.
- Priority: in IDLE, raise btn_dormir, btn_comer and btn_aula on the same cycle -> DORMINDO (00010).
- Timeout and max: with ACT_TIMEOUT=16, enter DANDO_AULA with felicidade=60 -> IDLE exactly 16 cycles after entry. Re-enter, then set felicidade=100 at cycle 5 -> IDLE on the next edge.
- Death: in DORMINDO, drive fome=0 while btn_dormir rises on the same cycle -> MORTO (10000) with morto=1. Death outranks the button. btn_start rise -> INTRO, then btn_start with fome still 0 -> IDLE, then MORTO one cycle later.
- Held button: in IDLE, hold btn_aula high for 100 cycles -> exactly one transition to DANDO_AULA, with no toggle-off while it is held.

Source files
------------

// File: rtl/controlador_estados.sv
// Pet behaviour state machine: synchronises the user buttons, picks the pet's
// activity and drives the estado bus consumed by the attribute controller.
module controlador_estados #(
  parameter int unsigned MAX_ATRIB   = 100,
  parameter int unsigned ACT_TIMEOUT = 67108864
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_dormir,
  input  logic       btn_comer,
  input  logic       btn_aula,
  input  logic [7:0] fome,
  input  logic [7:0] felicidade,
  input  logic [7:0] sono,
  output logic [4:0] estado,
  output logic       morto
);

  typedef enum logic [4:0] {
    INTRO      = 5'b00000,
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } state_t;

  localparam logic [7:0]  MAX_V        = 8'(MAX_ATRIB);
  localparam logic [31:0] TIMEOUT_LAST = 32'(ACT_TIMEOUT - 1);

  // Button bit order: 0 start, 1 dormir, 2 comer, 3 aula
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] rise;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        morto_q;

  logic        zero_any;
  logic        own_rise;
  logic        own_max;

  assign btn_raw  = {btn_aula, btn_comer, btn_dormir, btn_start};
  assign rise     = sync2_q & ~prev_q;
  assign zero_any = (fome == 8'd0) | (felicidade == 8'd0) | (sono == 8'd0);

  function automatic logic is_act(input state_t s);
    return (s == DORMINDO) || (s == COMENDO) || (s == DANDO_AULA);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      state_q <= INTRO;
      cnt_q   <= '0;
      morto_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      morto_q <= (state_d == MORTO);
    end
  end

  always_comb begin
    own_rise = 1'b0;
    own_max  = 1'b0;
    case (state_q)
      DORMINDO:   begin own_rise = rise[1]; own_max = (sono == MAX_V);       end
      COMENDO:    begin own_rise = rise[2]; own_max = (fome == MAX_V);       end
      DANDO_AULA: begin own_rise = rise[3]; own_max = (felicidade == MAX_V); end
      default:    begin own_rise = 1'b0;    own_max = 1'b0;                  end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INTRO: if (rise[0]) state_d = IDLE;
      MORTO: if (rise[0]) state_d = INTRO;
      IDLE: begin
        if (zero_any)     state_d = MORTO;
        else if (rise[1]) state_d = DORMINDO;
        else if (rise[2]) state_d = COMENDO;
        else if (rise[3]) state_d = DANDO_AULA;
      end
      DORMINDO, COMENDO, DANDO_AULA: begin
        // Own button is tested before the switch chain, so it never matches there
        if (zero_any)                   state_d = MORTO;
        else if (own_rise)              state_d = IDLE;
        else if (rise[1])               state_d = DORMINDO;
        else if (rise[2])               state_d = COMENDO;
        else if (rise[3])               state_d = DANDO_AULA;
        else if (own_max)               state_d = IDLE;
        else if (cnt_q == TIMEOUT_LAST) state_d = IDLE;
      end
      default: state_d = INTRO;
    endcase
  end

  // Entering (or switching) activity restarts at 0; staying counts up
  always_comb begin
    cnt_d = '0;
    if (is_act(state_d) && (state_d == state_q)) cnt_d = cnt_q + 32'd1;
  end

  assign estado = state_q;
  assign morto  = morto_q;

endmodule

// File: tb/tb_controlador_estados.sv
// Directed bench for controlador_estados with ACT_TIMEOUT shortened to 16.
module tb_controlador_estados;

  localparam logic [4:0] S_INTRO = 5'b00000;
  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_DORM  = 5'b00010;
  localparam logic [4:0] S_COM   = 5'b00100;
  localparam logic [4:0] S_AULA  = 5'b01000;
  localparam logic [4:0] S_MORTO = 5'b10000;

  // press masks: {aula, comer, dormir, start}
  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_DORM  = 4'b0010;
  localparam logic [3:0] B_COM   = 4'b0100;
  localparam logic [3:0] B_AULA  = 4'b1000;

  logic       clk;
  logic       rst_n;
  logic       btn_start, btn_dormir, btn_comer, btn_aula;
  logic [7:0] fome, felicidade, sono;
  logic [4:0] estado;
  logic       morto;

  int tests_run;
  int tests_failed;

  controlador_estados #(.MAX_ATRIB(100), .ACT_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_start  (btn_start),
    .btn_dormir (btn_dormir),
    .btn_comer  (btn_comer),
    .btn_aula   (btn_aula),
    .fome       (fome),
    .felicidade (felicidade),
    .sono       (sono),
    .estado     (estado),
    .morto      (morto)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] m);
    btn_start  = m[0];
    btn_dormir = m[1];
    btn_comer  = m[2];
    btn_aula   = m[3];
  endtask

  // Returns 1 unit after the 3rd edge from the first sample, when estado reflects the press
  task automatic press(input logic [3:0] m, input int hold);
    set_btns(m);
    tick(hold);
    set_btns(4'b0000);
    if (hold < 3) tick(3 - hold);
  endtask

  int entries;
  logic [4:0] prev_estado;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    set_btns(4'b0000);
    fome = 8'd50; felicidade = 8'd50; sono = 8'd50;

    // reset state
    tick(3);
    check("reset_estado", 32'(estado), 32'(S_INTRO));
    check("reset_morto", 32'(morto), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // INTRO ignores activity buttons
    press(B_COM, 1);
    tick(2);
    check("intro_ignores_comer", 32'(estado), 32'(S_INTRO));

    // start held 3 cycles: IDLE at 3rd edge, not before
    set_btns(B_START);
    tick(2);
    check("start_not_yet", 32'(estado), 32'(S_INTRO));
    tick(1);
    check("start_idle", 32'(estado), 32'(S_IDLE));
    set_btns(4'b0000);
    tick(5);
    check("idle_stays", 32'(estado), 32'(S_IDLE));

    // btn_start ignored in IDLE
    press(B_START, 1);
    tick(2);
    check("idle_ignores_start", 32'(estado), 32'(S_IDLE));

    // reset mid-activity
    press(B_COM, 1);
    check("enter_comendo_a", 32'(estado), 32'(S_COM));
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_estado", 32'(estado), 32'(S_INTRO));
    check("async_reset_morto", 32'(morto), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(2);
    press(B_START, 1);
    check("restart_idle", 32'(estado), 32'(S_IDLE));
    tick(2);

    // enter and toggle off; toggle outranks a simultaneous aula rise
    press(B_COM, 1);
    check("enter_comendo", 32'(estado), 32'(S_COM));
    tick(2);
    press(B_COM | B_AULA, 1);
    check("toggle_off_comer", 32'(estado), 32'(S_IDLE));
    tick(2);

    // priority dormir > comer > aula
    press(B_DORM | B_COM | B_AULA, 1);
    check("priority_dormir", 32'(estado), 32'(S_DORM));
    tick(2);
    press(B_COM, 1);
    check("switch_to_comendo", 32'(estado), 32'(S_COM));
    tick(2);
    press(B_COM, 1);
    check("switch_then_toggle", 32'(estado), 32'(S_IDLE));
    tick(2);

    // timeout: IDLE exactly 16 cycles after entry
    felicidade = 8'd60;
    press(B_AULA, 1);
    check("enter_aula", 32'(estado), 32'(S_AULA));
    tick(15);
    check("timeout_edge15", 32'(estado), 32'(S_AULA));
    tick(1);
    check("timeout_edge16", 32'(estado), 32'(S_IDLE));
    tick(2);

    // max: felicidade reaches 100 at cycle 5
    press(B_AULA, 1);
    check("reenter_aula", 32'(estado), 32'(S_AULA));
    tick(4);
    check("before_max", 32'(estado), 32'(S_AULA));
    felicidade = 8'd100;
    tick(1);
    check("max_exit", 32'(estado), 32'(S_IDLE));
    tick(2);

    // above max is not max
    felicidade = 8'd200;
    press(B_AULA, 1);
    tick(3);
    check("above_max_stays", 32'(estado), 32'(S_AULA));
    press(B_AULA, 1);
    check("above_max_toggle", 32'(estado), 32'(S_IDLE));
    felicidade = 8'd50;
    tick(2);

    // death outranks the own-button rise arriving on the same cycle
    press(B_DORM, 1);
    check("enter_dormindo", 32'(estado), 32'(S_DORM));
    tick(2);
    set_btns(B_DORM);
    tick(1);
    set_btns(4'b0000);
    tick(1);
    check("pre_death", 32'(estado), 32'(S_DORM));
    fome = 8'd0;
    tick(1);
    check("death_estado", 32'(estado), 32'(S_MORTO));
    check("death_morto", 32'(morto), 32'd1);
    tick(2);
    press(B_DORM, 1);
    tick(2);
    check("morto_ignores_dormir", 32'(estado), 32'(S_MORTO));
    press(B_START, 1);
    check("morto_to_intro", 32'(estado), 32'(S_INTRO));
    check("intro_morto_low", 32'(morto), 32'd0);
    tick(2);
    press(B_START, 1);
    check("zero_path_idle", 32'(estado), 32'(S_IDLE));
    check("zero_path_morto_low", 32'(morto), 32'd0);
    tick(1);
    check("zero_path_dead", 32'(estado), 32'(S_MORTO));
    check("zero_path_morto_high", 32'(morto), 32'd1);

    // revive
    fome = 8'd50;
    tick(2);
    press(B_START, 1);
    tick(2);
    press(B_START, 1);
    check("revive_idle", 32'(estado), 32'(S_IDLE));
    tick(2);

    // held aula: one entry, no toggle-off, timeout returns to IDLE
    entries = 0;
    prev_estado = estado;
    set_btns(B_AULA);
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (estado == S_AULA && prev_estado != S_AULA) entries++;
      if (i == 3)  check("held_enter", 32'(estado), 32'(S_AULA));
      if (i == 18) check("held_no_toggle", 32'(estado), 32'(S_AULA));
      if (i == 19) check("held_timeout", 32'(estado), 32'(S_IDLE));
      prev_estado = estado;
    end
    set_btns(4'b0000);
    tick(4);
    check("held_entries", 32'(entries), 32'd1);
    check("held_release_idle", 32'(estado), 32'(S_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
